ex_wb_pipe: RTL

Receiving end of the EX-stage result interface: takes the `{w_reg_data, w_reg_addr, wd}` triple each cycle and carries it through two pipeline registers (EX/MEM, MEM/WB). It commits the result into the 32×32 general register file and serves two combinational read ports for ID. Optional forwarding returns in-flight results to ID without waiting for commit.

---
 rtl/suu_defs.sv | 24 ++
 rtl/ex_wb_pipe_if.sv | 12 +
 rtl/suu_regfile.sv | 32 +++
 rtl/ex_wb_pipe.sv | 85 ++++++++
 4 files changed

// File: rtl/suu_defs.sv
// rtl/suu_defs.sv - shared widths, register-file constants and pipeline stage entry type
package suu_defs;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    // One in-flight writeback result: data, destination and write-enable
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              wd;
    } stage_t;

    localparam stage_t BUBBLE = '{data: '0, addr: '0, wd: 1'b0};

    // True when a stage entry will write the register being read (r0 never matches)
    function automatic logic fwd_hit(input stage_t s, input logic [ADDR_W-1:0] a);
        return s.wd && (s.addr == a) && (a != REG_ZERO);
    endfunction

endpackage

// File: rtl/ex_wb_pipe_if.sv
// rtl/ex_wb_pipe_if.sv - EX-stage result bundle {w_reg_data, w_reg_addr, wd}
interface ex_wb_pipe_if #(
    parameter int DATA_W = suu_defs::DATA_W,
    parameter int ADDR_W = suu_defs::ADDR_W
);
    logic [DATA_W-1:0] w_reg_data;
    logic [ADDR_W-1:0] w_reg_addr;
    logic              wd;

    modport master (output w_reg_data, output w_reg_addr, output wd);
    modport slave  (input  w_reg_data, input  w_reg_addr, input  wd);
endinterface

// File: rtl/suu_regfile.sv
// rtl/suu_regfile.sv - 32x32 register file, 2 combinational reads, 1 synchronous write, r0 reads 0
module suu_regfile
    import suu_defs::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Clear everything on reset; otherwise commit one write, discarding r0 writes
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != REG_ZERO)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rd_data_a = (rd_addr_a == REG_ZERO) ? '0 : regs[rd_addr_a];
    assign rd_data_b = (rd_addr_b == REG_ZERO) ? '0 : regs[rd_addr_b];

endmodule

// File: rtl/ex_wb_pipe.sv
// rtl/ex_wb_pipe.sv - EX/MEM and MEM/WB stage registers, regfile commit, ID read ports; WB_FWD_EN adds forwarding
module ex_wb_pipe #(
    parameter int DATA_W = suu_defs::DATA_W,
    parameter int ADDR_W = suu_defs::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    ex_wb_pipe_if.slave       ex,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data
);
    import suu_defs::*;

    stage_t            ex_mem;
    stage_t            mem_wb;
    logic [DATA_W-1:0] rf_data_a;
    logic [DATA_W-1:0] rf_data_b;

    // Advance the two stages; flush bubbles EX/MEM even while stalled, stall holds MEM/WB
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_mem <= BUBBLE;
            mem_wb <= BUBBLE;
        end else begin
            if (flush) begin
                ex_mem <= BUBBLE;
            end else if (!stall) begin
                ex_mem <= '{data: ex.w_reg_data, addr: ex.w_reg_addr, wd: ex.wd};
            end
            if (!stall) begin
                mem_wb <= ex_mem;
            end
        end
    end

    // A held WB entry commits once, on the first edge after stall drops
    assign wb_we   = mem_wb.wd && !stall && (mem_wb.addr != REG_ZERO);
    assign wb_addr = mem_wb.addr;
    assign wb_data = mem_wb.data;

    suu_regfile u_regfile (
        .clk       (clk),
        .rst       (rst),
        .we        (wb_we),
        .waddr     (wb_addr),
        .wdata     (wb_data),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rf_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rf_data_b)
    );

`ifdef WB_FWD_EN
    // Youngest in-flight result wins: EX/MEM, then MEM/WB, then the register file
    always_comb begin
        rd_data_a = rf_data_a;
        if (fwd_hit(ex_mem, rd_addr_a)) begin
            rd_data_a = ex_mem.data;
        end else if (fwd_hit(mem_wb, rd_addr_a)) begin
            rd_data_a = mem_wb.data;
        end
    end

    // Same priority for port B, independent of port A
    always_comb begin
        rd_data_b = rf_data_b;
        if (fwd_hit(ex_mem, rd_addr_b)) begin
            rd_data_b = ex_mem.data;
        end else if (fwd_hit(mem_wb, rd_addr_b)) begin
            rd_data_b = mem_wb.data;
        end
    end
`else
    assign rd_data_a = rf_data_a;
    assign rd_data_b = rf_data_b;
`endif

endmodule
